imem_arb: RTL and testbench

- Single-port arbiter sharing the combinational, byte-addressed instruction memory between two requesters: port 0 is instruction fetch (IF); port 1 is load/store read-only access (LS), used for constants and literal pools.
- Grants at most one access per cycle and drives the memory address combinationally from the winner.
- Registers the returned word and presents it to the winner one cycle later.
- Sits between the core's fetch/LSU and the imem block.

---
 rtl/imem_arb_pkg.sv | 17 +
 rtl/imem_arb_starve.sv | 37 +++
 rtl/imem_arb.sv | 120 ++++++++++++
 tb/tb_imem_arb.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_arb_pkg;

  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LS
  } owner_e;

  typedef enum logic {
    PRI_IF,
    FORCE_LS
  } state_e;

endpackage

// File: rtl/imem_arb_starve.sv
// Saturating count of cycles LS has waited with a request and no grant;
// force_ls flags the cycle whose next count reaches STARVE_MAX.
module imem_arb_starve
  import imem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ls_req,
  input  logic ls_gnt,
  output logic force_ls
);

  localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_next;

  always_comb begin
    starve_next = '0;
    if (ls_req && !ls_gnt) begin
      starve_next = (starve_cnt == CNT_MAX) ? CNT_MAX : starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_next;
    end
  end

  assign force_ls = (starve_next == CNT_MAX);

endmodule

// File: rtl/imem_arb.sv
// Two-port (fetch / load-store) arbiter in front of a combinational imem.
// Optional `IMEM_ARB_RR_EN selects round-robin tie-breaking instead of IF priority.
module imem_arb
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_e owner;
  logic   ls_wins_tie;

`ifdef IMEM_ARB_RR_EN
  logic last_ls;

  // Last winner was IF -> LS takes the next tie, and vice versa.
  assign ls_wins_tie = !last_ls;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ls <= 1'b1;
    end else if (if_gnt) begin
      last_ls <= 1'b0;
    end else if (ls_gnt) begin
      last_ls <= 1'b1;
    end
  end
`else
  state_e state;
  state_e state_next;
  logic   force_ls;

  imem_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .ls_req  (ls_req),
    .ls_gnt  (ls_gnt),
    .force_ls(force_ls)
  );

  assign ls_wins_tie = (state == FORCE_LS);

  always_comb begin
    state_next = state;
    unique case (state)
      PRI_IF:   if (force_ls) state_next = FORCE_LS;
      FORCE_LS: if (ls_gnt || !ls_req) state_next = PRI_IF;
      default:  state_next = PRI_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PRI_IF;
    end else begin
      state <= state_next;
    end
  end
`endif

  always_comb begin
    owner = OWN_NONE;
    if (!rst) begin
      if (if_req && ls_req) begin
        owner = ls_wins_tie ? OWN_LS : OWN_IF;
      end else if (if_req) begin
        owner = OWN_IF;
      end else if (ls_req) begin
        owner = OWN_LS;
      end
    end
  end

  assign if_gnt = (owner == OWN_IF);
  assign ls_gnt = (owner == OWN_LS);

  always_comb begin
    mem_addr = '0;
    unique case (owner)
      OWN_IF:  mem_addr = if_addr;
      OWN_LS:  mem_addr = ls_addr;
      default: mem_addr = '0;
    endcase
  end

  // A flush in the grant cycle drops the valid pulse but the data register still loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      if_rvalid <= if_gnt && !if_flush;
      ls_rvalid <= ls_gnt;
      if (if_gnt) if_rdata <= mem_rdata;
      if (ls_gnt) ls_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_arb.sv
// Table-driven bench for imem_arb with a response scoreboard and a model imem.
module tb_imem_arb;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req;
  logic [ADDR_W-1:0] ls_addr;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              ls_req;
    logic [ADDR_W-1:0] ls_addr;
    logic              e_if_gnt;
    logic              e_ls_gnt;
  } vec_t;

  typedef struct {
    logic              if_v;
    logic [DATA_W-1:0] if_d;
    logic              ls_v;
    logic [DATA_W-1:0] ls_d;
  } resp_t;

  vec_t  vecs[$];
  resp_t sb[$];

  function automatic logic [DATA_W-1:0] memf(input logic [ADDR_W-1:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  assign mem_rdata = memf(mem_addr);

  imem_arb #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .ls_req   (ls_req),
    .ls_addr  (ls_addr),
    .ls_gnt   (ls_gnt),
    .ls_rvalid(ls_rvalid),
    .ls_rdata (ls_rdata),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (actual=timeout required=finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic ir, input logic [ADDR_W-1:0] ia,
                              input logic fl, input logic lr, input logic [ADDR_W-1:0] la,
                              input logic eig, input logic elg);
    vec_t v;
    v.rst = r; v.if_req = ir; v.if_addr = ia; v.if_flush = fl;
    v.ls_req = lr; v.ls_addr = la; v.e_if_gnt = eig; v.e_ls_gnt = elg;
    vecs.push_back(v);
  endfunction

  initial begin
    resp_t             exp_r;
    resp_t             got;
    logic [DATA_W-1:0] m_if_d;
    logic [DATA_W-1:0] m_ls_d;
    logic [ADDR_W-1:0] e_addr;

    // Reset with ls_req held high: no grants, then the pending request is dropped.
    add(1, 0, 0, 0, 1, 32'h100, 0, 0);
    add(1, 1, 0, 0, 1, 32'h100, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,   0, 0);
`ifdef IMEM_ARB_RR_EN
    // Ties alternate, IF first.
    for (int unsigned i = 0; i < 6; i++) begin
      add(0, 1, 32'h10 + 4 * i, 0, 1, 32'h100 + 4 * i, (i % 2) == 0, (i % 2) == 1);
    end
`else
    // Continuous contention: IF wins four cycles, LS is forced on the fifth.
    add(0, 1, 32'h10, 0, 1, 32'h100, 1, 0);
    add(0, 1, 32'h14, 0, 1, 32'h100, 1, 0);
    add(0, 1, 32'h18, 0, 1, 32'h100, 1, 0);
    add(0, 1, 32'h1C, 0, 1, 32'h100, 1, 0);
    add(0, 1, 32'h20, 0, 1, 32'h100, 0, 1);
    add(0, 1, 32'h20, 0, 0, 32'h0,   1, 0);
`endif
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // IF-only back-to-back.
    add(0, 1, 32'h0, 0, 0, 0, 1, 0);
    add(0, 1, 32'h4, 0, 0, 0, 1, 0);
    add(0, 1, 32'h8, 0, 0, 0, 1, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0);
    // Flush in grant cycle suppresses rvalid; flush one cycle late does not.
    add(0, 1, 32'h20, 1, 0, 0, 1, 0);
    add(0, 0, 0,      0, 0, 0, 0, 0);
    add(0, 1, 32'h24, 0, 0, 0, 1, 0);
    add(0, 0, 0,      1, 0, 0, 0, 0);
    // LS with a concurrent flush completes normally.
    add(0, 0, 0, 1, 1, 32'h40, 0, 1);
    add(0, 0, 0, 0, 0, 0,      0, 0);
    // LS-only alone, then random IF burst.
    add(0, 0, 0, 0, 1, 32'h7FFF_FFFD, 0, 1);
    for (int unsigned i = 0; i < 8; i++) begin
      add(0, 1, {22'h0, 8'($urandom_range(0, 255)), 2'b00}, 0, 0, 0, 1, 0);
    end
    add(0, 0, 0, 0, 0, 0, 0, 0);
`ifndef IMEM_ARB_RR_EN
    // LS drops its request early: the starve count restarts from zero.
    add(0, 1, 32'h50, 0, 1, 32'h200, 1, 0);
    add(0, 1, 32'h54, 0, 1, 32'h200, 1, 0);
    add(0, 1, 32'h58, 0, 0, 32'h0,   1, 0);
    add(0, 1, 32'h5C, 0, 1, 32'h204, 1, 0);
    add(0, 1, 32'h60, 0, 1, 32'h204, 1, 0);
    add(0, 1, 32'h64, 0, 1, 32'h204, 1, 0);
    add(0, 1, 32'h68, 0, 1, 32'h204, 1, 0);
    add(0, 1, 32'h6C, 0, 1, 32'h204, 0, 1);
    // Mid-stream reset also clears the starve count and the data registers.
    add(0, 1, 32'h70, 0, 1, 32'h300, 1, 0);
    add(0, 1, 32'h74, 0, 1, 32'h300, 1, 0);
    add(1, 1, 32'h78, 0, 1, 32'h300, 0, 0);
    add(0, 1, 32'h78, 0, 1, 32'h300, 1, 0);
    add(0, 1, 32'h7C, 0, 1, 32'h300, 1, 0);
    add(0, 1, 32'h80, 0, 1, 32'h300, 1, 0);
    add(0, 1, 32'h84, 0, 1, 32'h300, 1, 0);
    add(0, 1, 32'h88, 0, 1, 32'h300, 0, 1);
    add(0, 0, 0,      0, 0, 0,       0, 0);
`endif

    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0; ls_req = 1'b1; ls_addr = 32'h100;
    @(posedge clk);
    m_if_d = '0;
    m_ls_d = '0;
    exp_r = '{1'b0, '0, 1'b0, '0};
    sb.push_back(exp_r);

    foreach (vecs[i]) begin
      #1;
      rst = vecs[i].rst; if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      if_flush = vecs[i].if_flush; ls_req = vecs[i].ls_req; ls_addr = vecs[i].ls_addr;
      @(negedge clk);

      if (sb.size() == 0) begin
        chk("sb_empty", i, 32'(sb.size()), 32'd1);
      end else begin
        got = sb.pop_front();
        chk("if_rvalid", i, 32'(if_rvalid), 32'(got.if_v));
        chk("if_rdata",  i, if_rdata,       got.if_d);
        chk("ls_rvalid", i, 32'(ls_rvalid), 32'(got.ls_v));
        chk("ls_rdata",  i, ls_rdata,       got.ls_d);
      end

      chk("if_gnt", i, 32'(if_gnt), 32'(vecs[i].e_if_gnt));
      chk("ls_gnt", i, 32'(ls_gnt), 32'(vecs[i].e_ls_gnt));
      e_addr = vecs[i].e_if_gnt ? vecs[i].if_addr : (vecs[i].e_ls_gnt ? vecs[i].ls_addr : '0);
      chk("mem_addr", i, mem_addr, e_addr);

      if (vecs[i].rst) begin
        m_if_d = '0;
        m_ls_d = '0;
        exp_r = '{1'b0, '0, 1'b0, '0};
      end else begin
        if (vecs[i].e_if_gnt) m_if_d = memf(vecs[i].if_addr);
        if (vecs[i].e_ls_gnt) m_ls_d = memf(vecs[i].ls_addr);
        exp_r.if_v = vecs[i].e_if_gnt && !vecs[i].if_flush;
        exp_r.if_d = m_if_d;
        exp_r.ls_v = vecs[i].e_ls_gnt;
        exp_r.ls_d = m_ls_d;
      end
      sb.push_back(exp_r);
      @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
